// File: rtl/mem_stage_ld_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_ld_pkg
// Shared definitions for the memory stage:
//   - load-operation encoding carried on the EX->MS bus (ld_op field)
//   - helpers that compute the EX->MS and MS->WB bus widths from the
//     register-file address, data and PC widths
// ---------------------------------------------------------------------------
package mem_stage_ld_pkg;

    localparam int LD_OP_W = 3;

    // Codes 5..7 are unused and behave as a full-word load.
    typedef enum logic [LD_OP_W-1:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_op_e;

    // {res_from_mem, req_issued, ld_op, gr_we, dest, alu_res, pc}
    function automatic int es_to_ms_bus_wd(input int rf_aw, input int xlen, input int pc_w);
        return 2 + LD_OP_W + 1 + rf_aw + xlen + pc_w;
    endfunction

    // {gr_we, dest, final_res, pc}
    function automatic int ms_to_ws_bus_wd(input int rf_aw, input int xlen, input int pc_w);
        return 1 + rf_aw + xlen + pc_w;
    endfunction

endpackage

// File: rtl/mem_stage_ld_load_ext.sv
// ---------------------------------------------------------------------------
// mem_stage_ld_load_ext
// Purely combinational sub-word load extraction for a 32-bit data path.
// Ports:
//   ld_op_i   load operation code (ld_op_e)
//   addr_i    low two address bits selecting byte / halfword lane
//   word_i    full 32-bit word returned by memory
//   result_o  extracted, sign- or zero-extended value
// Misaligned halfword addresses are not flagged; addr_i[0] is ignored for
// halfword loads.
// ---------------------------------------------------------------------------
module mem_stage_ld_load_ext
    import mem_stage_ld_pkg::*;
(
    input  logic [LD_OP_W-1:0] ld_op_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        word_i,
    output logic [31:0]        result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        result_o = word_i;
        case (ld_op_i)
            LD_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result_o = {24'd0, byte_sel};
            LD_H:    result_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result_o = {16'd0, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_ld.sv
// ---------------------------------------------------------------------------
// mem_stage_ld
// Memory stage of the 5-stage pipeline with a variable-latency data-SRAM
// read response (data_ok handshake, responses in request order).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ws_allowin                 WB can accept
//   ms_allowin                 MS can accept from EX
//   es_to_ms_valid/_bus        EX payload
//   ms_to_ws_valid/_bus        payload to WB {gr_we, dest, final_res, pc}
//   data_sram_data_ok/_rdata   one read response per data_ok pulse
//   flush                      kill stage contents
//   ms_fwd_we/_dest/_data      forwarding view for ID
//   ms_fwd_stall               load in MS still waiting for its data
//   ms_discard_busy            responses of flushed loads still pending
// Only XLEN = 32 is supported by the sub-word extractor.
// ---------------------------------------------------------------------------
module mem_stage_ld
    import mem_stage_ld_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int PC_W            = 32,
    parameter int RF_AW           = 5,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ES_TO_MS_BUS_WD = es_to_ms_bus_wd(RF_AW, XLEN, PC_W),
    parameter int MS_TO_WS_BUS_WD = ms_to_ws_bus_wd(RF_AW, XLEN, PC_W)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [XLEN-1:0]            data_sram_rdata,
    input  logic                       flush,
    output logic                       ms_fwd_we,
    output logic [RF_AW-1:0]           ms_fwd_dest,
    output logic [XLEN-1:0]            ms_fwd_data,
    output logic                       ms_fwd_stall,
    output logic                       ms_discard_busy
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                       ms_valid_q, ms_valid_d;
    logic                       have_data_q, have_data_d;
    logic [CNT_W-1:0]           discard_cnt_q, discard_cnt_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
    logic [XLEN-1:0]            rdata_buf_q, rdata_buf_d;

    logic               res_from_mem, req_issued, gr_we;
    logic [LD_OP_W-1:0] ld_op;
    logic [RF_AW-1:0]   dest;
    logic [XLEN-1:0]    alu_res;
    logic [PC_W-1:0]    pc;

    assign {res_from_mem, req_issued, ld_op, gr_we, dest, alu_res, pc} = bus_q;

    logic            need_data, discarding, resp_mine, ms_ready_go;
    logic            disc_inc, disc_dec;
    logic [XLEN-1:0] ld_word, ld_result, final_res;

    assign need_data   = ms_valid_q && res_from_mem && req_issued;
    assign discarding  = discard_cnt_q != '0;
    // While older flushed responses are still in flight, every data_ok
    // belongs to them, never to the load currently held here.
    assign resp_mine   = data_sram_data_ok && !discarding && need_data && !have_data_q;
    assign ms_ready_go = !need_data || have_data_q || resp_mine;

    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;

    // Zero-wait responses pass straight through; stalled ones come from the buffer.
    assign ld_word = have_data_q ? rdata_buf_q : data_sram_rdata;

    mem_stage_ld_load_ext u_load_ext (
        .ld_op_i  (ld_op),
        .addr_i   (alu_res[1:0]),
        .word_i   (ld_word),
        .result_o (ld_result)
    );

    // A load whose request was never issued carries its ALU result through.
    assign final_res = (res_from_mem && req_issued) ? ld_result : alu_res;

    assign ms_to_ws_bus    = {gr_we, dest, final_res, pc};
    assign ms_fwd_we       = ms_valid_q && gr_we;
    assign ms_fwd_dest     = dest;
    assign ms_fwd_data     = final_res;
    assign ms_fwd_stall    = need_data && !ms_ready_go;
    assign ms_discard_busy = discarding;

    // A flushed load that is still owed a response leaves one to be dropped.
    assign disc_inc = flush && need_data && !have_data_q && !resp_mine;
    assign disc_dec = data_sram_data_ok && discarding;

    always_comb begin
        ms_valid_d    = ms_valid_q;
        have_data_d   = have_data_q;
        bus_d         = bus_q;
        rdata_buf_d   = rdata_buf_q;
        discard_cnt_d = discard_cnt_q;

        if (flush) begin
            ms_valid_d  = 1'b0;
            have_data_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d  = es_to_ms_valid;
            have_data_d = 1'b0;
            if (es_to_ms_valid) begin
                bus_d = es_to_ms_bus;
            end
        end else if (resp_mine) begin
            // Not allowed in while holding our response means WB is stalled.
            have_data_d = 1'b1;
            rdata_buf_d = data_sram_rdata;
        end

        if (disc_inc && !disc_dec) begin
            if (discard_cnt_q != CNT_W'(MAX_OUTSTANDING)) begin
                discard_cnt_d = discard_cnt_q + CNT_W'(1);
            end
        end else if (disc_dec && !disc_inc) begin
            discard_cnt_d = discard_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            have_data_q   <= 1'b0;
            discard_cnt_q <= '0;
            bus_q         <= '0;
            rdata_buf_q   <= '0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            have_data_q   <= have_data_d;
            discard_cnt_q <= discard_cnt_d;
            bus_q         <= bus_d;
            rdata_buf_q   <= rdata_buf_d;
        end
    end

endmodule
